// File: rtl/acc_irq_pkg.sv
// Shared definitions for the Acclaim MC-ACC scanline IRQ engine.
//   - register indices decoded from {cpu.addr[15:13], cpu.addr[0]}
//   - save-state bus structure and per-block offsets
//   - packed layout of the status byte exposed at save-state offset 2
package acc_irq_pkg;

  localparam int unsigned SST_AW = 10;

  typedef enum logic [3:0] {
    REG_LATCH  = 4'hC,
    REG_RELOAD = 4'hD,
    REG_DIS    = 4'hE,
    REG_EN     = 4'hF
  } acc_reg_e;

  localparam logic [1:0] SST_OFF_LATCH = 2'd0;
  localparam logic [1:0] SST_OFF_CNT   = 2'd1;
  localparam logic [1:0] SST_OFF_STAT  = 2'd2;
  localparam logic [1:0] SST_OFF_SYNC  = 2'd3;

  typedef struct packed {
    logic              act;
    logic              we_reg;
    logic [SST_AW-1:0] addr;
    logic [7:0]        dato;
  } SSTBus;

  typedef struct packed {
    logic       m2_seen;
    logic       rsvd;
    logic       irq_pend;
    logic       irq_en;
    logic       reload;
    logic [2:0] pre;
  } acc_stat_t;

endpackage

// File: rtl/acc_a12_edge.sv
// PPU A12 synchronizer and falling-edge detector, with an optional M2 filter.
// Build option: define ACC_IRQ_M2FILT_EN to accept a fall only when a
// synchronized cpu_m2 rising edge has occurred since the last accepted fall.
// Ports:
//   clk_i, rst_ni    clock, synchronous active-low reset
//   hold_i           freezes all flops and suppresses a12_fall_o (save-state active)
//   a12_i, m2_i      raw PPU A12 and CPU M2 (asynchronous)
//   seen_we_i/di_i   save-state load of the "m2 seen" flag
//   a12_fall_o       one-clk pulse per accepted A12 falling edge
//   sync_o           {prev, s1, s0}
//   m2_seen_o        current "m2 seen" flag (0 when the filter is not built)
module acc_a12_edge (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       hold_i,
  input  logic       a12_i,
  input  logic       m2_i,
  input  logic       seen_we_i,
  input  logic       seen_di_i,
  output logic       a12_fall_o,
  output logic [2:0] sync_o,
  output logic       m2_seen_o
);

  logic s0_q, s1_q, prev_q;
  logic fall_raw;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
      prev_q <= 1'b0;
    end else if (!hold_i) begin
      s0_q   <= a12_i;
      s1_q   <= s0_q;
      prev_q <= s1_q;
    end
  end

  assign fall_raw = prev_q & ~s1_q & ~hold_i;
  assign sync_o   = {prev_q, s1_q, s0_q};

`ifdef ACC_IRQ_M2FILT_EN
  logic m0_q, m1_q, mprev_q, seen_q;
  logic m2_rise;

  assign m2_rise = m1_q & ~mprev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      m0_q    <= 1'b0;
      m1_q    <= 1'b0;
      mprev_q <= 1'b0;
      seen_q  <= 1'b1;
    end else if (hold_i) begin
      if (seen_we_i) seen_q <= seen_di_i;
    end else begin
      m0_q    <= m2_i;
      m1_q    <= m0_q;
      mprev_q <= m1_q;
      // an M2 rise coincident with an accepted fall is consumed by that fall
      if (fall_raw && (seen_q || m2_rise)) seen_q <= 1'b0;
      else if (m2_rise)                    seen_q <= 1'b1;
    end
  end

  assign a12_fall_o = fall_raw & (seen_q | m2_rise);
  assign m2_seen_o  = seen_q;
`else
  logic unused_m2;
  assign unused_m2  = ^{m2_i, seen_we_i, seen_di_i};
  assign a12_fall_o = fall_raw;
  assign m2_seen_o  = 1'b0;
`endif

endmodule

// File: rtl/acc_scanline_irq.sv
// Scanline IRQ engine for the Acclaim MC-ACC variant of mapper 4.
// PPU A12 falling edges feed a 2^PRE_BITS prescaler that clocks an 8-bit
// down-counter with reload latch; reaching zero while enabled raises irq.
// Build option: ACC_IRQ_M2FILT_EN (M2-qualified A12 edges, see acc_a12_edge).
// Ports:
//   clk, map_rst_n     clock, synchronous active-low reset
//   decode_en          one-clk CPU write strobe
//   reg_addr           {cpu.addr[15:13], cpu.addr[0]}
//   cpu_data           CPU write data
//   cpu_m2, ppu_a12    raw CPU M2 / PPU A12
//   sst                save-state bus
//   irq                level IRQ request (registered)
//   sst_ce, sst_do     save-state address hit and read data
module acc_scanline_irq
  import acc_irq_pkg::*;
#(
  parameter int unsigned SST_BASE = 16,
  parameter int unsigned PRE_BITS = 3
) (
  input  logic       clk,
  input  logic       map_rst_n,
  input  logic       decode_en,
  input  logic [3:0] reg_addr,
  input  logic [7:0] cpu_data,
  input  logic       cpu_m2,
  input  logic       ppu_a12,
  input  SSTBus      sst,
  output logic       irq,
  output logic       sst_ce,
  output logic [7:0] sst_do
);

  logic [7:0]          latch_q, latch_d;
  logic [7:0]          cnt_q, cnt_d, cnt_nx;
  logic [PRE_BITS-1:0] pre_q, pre_d;
  logic                reload_q, reload_d;
  logic                en_q, en_d;
  logic                pend_q, pend_d;

  logic              a12_fall, tick, m2_seen;
  logic [2:0]        sync_st;
  logic [SST_AW-1:0] sst_off_full;
  logic [1:0]        sst_off;
  logic              sst_wr, cpu_wr;
  acc_stat_t         stat;
  logic              unused_sst;

  // Wrapping subtraction makes addresses below the base land out of range.
  assign sst_off_full = sst.addr - SST_AW'(SST_BASE);
  assign sst_ce       = (sst_off_full < SST_AW'(4));
  assign sst_off      = sst_off_full[1:0];
  assign sst_wr       = sst.act & sst.we_reg & sst_ce;
  assign cpu_wr       = decode_en & ~sst.act;
  assign unused_sst   = sst.dato[6];

  acc_a12_edge u_edge (
    .clk_i      (clk),
    .rst_ni     (map_rst_n),
    .hold_i     (sst.act),
    .a12_i      (ppu_a12),
    .m2_i       (cpu_m2),
    .seen_we_i  (sst_wr && (sst_off == SST_OFF_STAT)),
    .seen_di_i  (sst.dato[7]),
    .a12_fall_o (a12_fall),
    .sync_o     (sync_st),
    .m2_seen_o  (m2_seen)
  );

  assign tick = a12_fall & (pre_q == '1);

  always_comb begin
    stat          = '0;
    stat.m2_seen  = m2_seen;
    stat.irq_pend = pend_q;
    stat.irq_en   = en_q;
    stat.reload   = reload_q;
    stat.pre      = 3'(pre_q);
  end

  always_comb begin
    sst_do = '0;
    if (sst_ce) begin
      case (sst_off)
        SST_OFF_LATCH: sst_do = latch_q;
        SST_OFF_CNT:   sst_do = cnt_q;
        SST_OFF_STAT:  sst_do = stat;
        default:       sst_do = {5'b0, sync_st};
      endcase
    end
  end

  always_comb begin
    latch_d  = latch_q;
    cnt_d    = cnt_q;
    cnt_nx   = cnt_q;
    pre_d    = pre_q;
    reload_d = reload_q;
    en_d     = en_q;
    pend_d   = pend_q;
    if (sst_wr) begin
      case (sst_off)
        SST_OFF_LATCH: latch_d = sst.dato;
        SST_OFF_CNT:   cnt_d   = sst.dato;
        SST_OFF_STAT: begin
          pend_d   = sst.dato[5];
          en_d     = sst.dato[4];
          reload_d = sst.dato[3];
          pre_d    = PRE_BITS'(sst.dato[2:0]);
        end
        default: ;
      endcase
    end else if (!sst.act) begin
      if (a12_fall) pre_d = pre_q + PRE_BITS'(1);
      // A reload write in the tick cycle discards the tick entirely; the
      // counter loads latch_q so a same-cycle latch write is not yet visible.
      if (tick && !(cpu_wr && reg_addr == REG_RELOAD)) begin
        if (cnt_q == 8'd0 || reload_q) begin
          cnt_nx   = latch_q;
          reload_d = 1'b0;
        end else begin
          cnt_nx = cnt_q - 8'd1;
        end
        cnt_d = cnt_nx;
        if (cnt_nx == 8'd0 && en_q) pend_d = 1'b1;
      end
      if (cpu_wr) begin
        case (reg_addr)
          REG_LATCH:  latch_d = cpu_data;
          REG_RELOAD: begin
            reload_d = 1'b1;
            pre_d    = '0;
          end
          REG_DIS: begin
            en_d   = 1'b0;
            pend_d = 1'b0;
          end
          REG_EN:     en_d = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!map_rst_n) begin
      latch_q  <= '0;
      cnt_q    <= '0;
      pre_q    <= '0;
      reload_q <= 1'b0;
      en_q     <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      latch_q  <= latch_d;
      cnt_q    <= cnt_d;
      pre_q    <= pre_d;
      reload_q <= reload_d;
      en_q     <= en_d;
      pend_q   <= pend_d;
    end
  end

  assign irq = pend_q;

endmodule

// File: tb/tb_acc_scanline_irq.sv
module tb_acc_scanline_irq;
  import acc_irq_pkg::*;

  localparam int unsigned BASE = 16;

`ifdef ACC_IRQ_M2FILT_EN
  localparam logic [7:0] STAT_RST = 8'h80;
  localparam logic [7:0] SST_STAT_W = 8'h97;
`else
  localparam logic [7:0] STAT_RST = 8'h00;
  localparam logic [7:0] SST_STAT_W = 8'h17;
`endif

  logic       clk = 1'b0;
  logic       map_rst_n = 1'b0;
  logic       decode_en = 1'b0;
  logic [3:0] reg_addr = '0;
  logic [7:0] cpu_data = '0;
  logic       cpu_m2 = 1'b0;
  logic       ppu_a12 = 1'b0;
  SSTBus      sst = '0;
  logic       irq;
  logic       sst_ce;
  logic [7:0] sst_do;

  int unsigned compares = 0;
  int unsigned fails = 0;
  string       tag_q[$];
  logic [7:0]  exp_q[$];

  acc_scanline_irq #(.SST_BASE(BASE), .PRE_BITS(3)) dut (
    .clk       (clk),
    .map_rst_n (map_rst_n),
    .decode_en (decode_en),
    .reg_addr  (reg_addr),
    .cpu_data  (cpu_data),
    .cpu_m2    (cpu_m2),
    .ppu_a12   (ppu_a12),
    .sst       (sst),
    .irq       (irq),
    .sst_ce    (sst_ce),
    .sst_do    (sst_do)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic push(input string t, input logic [7:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [7:0] obs);
    string t;
    logic [7:0] e;
    compares++;
    if (tag_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed %0h, expected a queued value", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  task automatic rd_chk(input logic [1:0] off, input string t, input logic [7:0] e);
    push(t, e);
    @(negedge clk);
    sst.addr = SST_AW'(BASE + off);
    #1;
    chk(sst_do);
  endtask

  task automatic irq_chk(input string t, input logic e);
    push(t, {7'b0, e});
    chk({7'b0, irq});
  endtask

  task automatic cpu_wr(input logic [3:0] r, input logic [7:0] d);
    @(negedge clk);
    decode_en = 1'b1;
    reg_addr  = r;
    cpu_data  = d;
    @(negedge clk);
    decode_en = 1'b0;
  endtask

  task automatic sst_wr(input logic [1:0] off, input logic [7:0] d);
    @(negedge clk);
    sst.addr   = SST_AW'(BASE + off);
    sst.dato   = d;
    sst.we_reg = 1'b1;
    @(negedge clk);
    sst.we_reg = 1'b0;
  endtask

  // A12/M2 high for 3 clk then low for 3 clk; the fall is fully consumed on return.
  task automatic a12_edge();
    @(negedge clk);
    ppu_a12 = 1'b1;
    cpu_m2  = 1'b1;
    repeat (3) @(negedge clk);
    ppu_a12 = 1'b0;
    cpu_m2  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic edges(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) a12_edge();
  endtask

  initial begin
    int unsigned n;

    // reset state
    repeat (3) @(negedge clk);
    map_rst_n = 1'b1;
    irq_chk("rst_irq", 1'b0);
    rd_chk(SST_OFF_LATCH, "rst_latch", 8'h00);
    rd_chk(SST_OFF_CNT,   "rst_cnt",   8'h00);
    rd_chk(SST_OFF_STAT,  "rst_stat",  STAT_RST);
    rd_chk(SST_OFF_SYNC,  "rst_sync",  8'h00);
    push("ce_in_range", 8'h01);
    chk({7'b0, sst_ce});
    @(negedge clk);
    sst.addr = SST_AW'(BASE + 4);
    #1;
    push("ce_above", 8'h00);
    chk({7'b0, sst_ce});
    sst.addr = SST_AW'(BASE - 1);
    #1;
    push("ce_below", 8'h00);
    chk({7'b0, sst_ce});

    // latch=3, reload, enable, 32 falls
    cpu_wr(REG_LATCH, 8'd3);
    cpu_wr(REG_RELOAD, 8'h00);
    cpu_wr(REG_EN, 8'h00);
    edges(8);
    rd_chk(SST_OFF_CNT, "t1_cnt_8", 8'd3);
    edges(8);
    rd_chk(SST_OFF_CNT, "t1_cnt_16", 8'd2);
    edges(8);
    rd_chk(SST_OFF_CNT, "t1_cnt_24", 8'd1);
    edges(7);
    irq_chk("t1_irq_31", 1'b0);
    @(negedge clk);
    ppu_a12 = 1'b1;
    cpu_m2  = 1'b1;
    repeat (3) @(negedge clk);
    ppu_a12 = 1'b0;
    cpu_m2  = 1'b0;
    n = 0;
    while (irq !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    push("t1_irq_latency_3to4", 8'h01);
    chk({7'b0, (n >= 3 && n <= 4)});
    repeat (2) @(negedge clk);
    rd_chk(SST_OFF_CNT, "t1_cnt_32", 8'd0);

    // disable clears, re-enable, reload to 3 with no irq
    cpu_wr(REG_DIS, 8'h00);
    irq_chk("t2_irq_cleared", 1'b0);
    cpu_wr(REG_EN, 8'h00);
    edges(8);
    rd_chk(SST_OFF_CNT, "t2_cnt_reload", 8'd3);
    irq_chk("t2_irq_none", 1'b0);

    // reload write colliding with a tick
    cpu_wr(REG_LATCH, 8'd6);
    edges(7);
    rd_chk(SST_OFF_STAT, "t3_stat_pre7", 8'h17);
    @(negedge clk);
    ppu_a12 = 1'b1;
    cpu_m2  = 1'b1;
    repeat (3) @(negedge clk);
    ppu_a12 = 1'b0;
    cpu_m2  = 1'b0;
    repeat (2) @(negedge clk);
    decode_en = 1'b1;
    reg_addr  = REG_RELOAD;
    @(negedge clk);
    decode_en = 1'b0;
    rd_chk(SST_OFF_STAT, "t3_stat_after_d", 8'h18);
    rd_chk(SST_OFF_CNT,  "t3_cnt_kept",     8'd3);
    edges(7);
    rd_chk(SST_OFF_CNT,  "t3_cnt_no_tick",  8'd3);
    rd_chk(SST_OFF_STAT, "t3_stat_pre7b",   8'h1F);
    edges(1);
    rd_chk(SST_OFF_CNT,  "t3_cnt_reloaded", 8'd6);
    rd_chk(SST_OFF_STAT, "t3_stat_clean",   8'h10);

    // latch=0: irq every tick
    cpu_wr(REG_LATCH, 8'd0);
    cpu_wr(REG_RELOAD, 8'h00);
    edges(7);
    irq_chk("t4_irq_pre", 1'b0);
    edges(1);
    irq_chk("t4_irq_tick1", 1'b1);
    cpu_wr(REG_DIS, 8'h00);
    irq_chk("t4_irq_dropped", 1'b0);
    edges(8);
    irq_chk("t4_irq_disabled_tick", 1'b0);
    cpu_wr(REG_EN, 8'h00);
    edges(8);
    irq_chk("t4_irq_tick3", 1'b1);

    // save state
    @(negedge clk);
    sst.act = 1'b1;
    sst_wr(SST_OFF_LATCH, 8'h5A);
    sst_wr(SST_OFF_CNT,   8'h02);
    sst_wr(SST_OFF_STAT,  SST_STAT_W);
    sst_wr(SST_OFF_SYNC,  8'hFF);
    cpu_wr(REG_LATCH, 8'h11);
    rd_chk(SST_OFF_LATCH, "t5_latch", 8'h5A);
    rd_chk(SST_OFF_CNT,   "t5_cnt",   8'h02);
    rd_chk(SST_OFF_STAT,  "t5_stat",  SST_STAT_W);
    rd_chk(SST_OFF_SYNC,  "t5_sync",  8'h00);
    irq_chk("t5_irq", 1'b0);
    @(negedge clk);
    sst.act = 1'b0;
    edges(8);
    rd_chk(SST_OFF_CNT, "t5_cnt_after", 8'd1);
    irq_chk("t5_irq_after", 1'b0);

    // reset mid-operation
    edges(1);
    irq_chk("t6_irq_set", 1'b1);
    cpu_wr(REG_LATCH, 8'd5);
    edges(8);
    rd_chk(SST_OFF_CNT, "t6_cnt5", 8'd5);
    irq_chk("t6_irq_held", 1'b1);
    @(negedge clk);
    map_rst_n  = 1'b0;
    sst.act    = 1'b1;
    sst.we_reg = 1'b1;
    sst.addr   = SST_AW'(BASE);
    sst.dato   = 8'hAA;
    decode_en  = 1'b1;
    reg_addr   = REG_LATCH;
    cpu_data   = 8'h77;
    @(negedge clk);
    map_rst_n  = 1'b1;
    sst        = '0;
    decode_en  = 1'b0;
    irq_chk("t6_irq_rst", 1'b0);
    rd_chk(SST_OFF_LATCH, "t6_latch_rst", 8'h00);
    rd_chk(SST_OFF_CNT,   "t6_cnt_rst",   8'h00);
    rd_chk(SST_OFF_STAT,  "t6_stat_rst",  STAT_RST);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
